soc_system_pll_lock_monitor: RTL and testbench
==============================================

Name: soc_system_pll_lock_monitor

Overview:
- Controls and supervises the stream PLL. Drives the PLL's active-high reset and watches its asynchronous `locked` output.
- Releases the stream-domain reset only after lock has been stable for a programmed time. Re-sequences the PLL on lock timeout, lock loss or software request.
- Runs on the free-running 50 MHz reference clock, the same clock that feeds the PLL. Sits between the PLL wrapper and the per-domain reset synchronizers of outclk_0/outclk_1 logic.

Parameters:
- SYNC_STAGES, 2, flops in the pll_locked synchronizer (min 2).
- PLL_RST_CYCLES, 16, cycles pll_rst is held high per reset pulse (min 1).
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before re-pulsing pll_rst.
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release (min 1).
- LOSS_W, 8, width of the lock-loss counter.

Ports:
- clk  in  1  reference clock (50 MHz, free-running).
- reset_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked, asynchronous to clk.
- force_relock  in  1  single-cycle request to re-sequence the PLL.
- clear_loss  in  1  single-cycle clear of loss_count.
- pll_rst  out  1  active-high reset to PLL.
- stream_reset_n  out  1  active-low reset for stream domains; high only in RUN.
- lock_ok  out  1  high only in RUN.
- loss_count  out  LOSS_W  saturating count of lock losses seen in RUN.
- timeout_count  out  LOSS_W  saturating count of WAIT_LOCK timeouts.
- state_o  out  2  current state encoding.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous assert, synchronous deassert at the source, and active-low.
- Reset values: state=PLL_RST, pll_rst=1, stream_reset_n=0, lock_ok=0, loss_count=0, timeout_count=0, all counters 0, synchronizer flops 0.
- Output timing: all outputs are registered and change on the same edge as the state transition. There is no combinational path from an input to an output.
- Synchronizer: lock_s is pll_locked passed through SYNC_STAGES flops. The FSM uses only lock_s.
- State PLL_RST (encoding 0): pll_rst=1. The counter runs 0..PLL_RST_CYCLES-1, then the FSM goes to WAIT_LOCK with the counter cleared. pll_rst is high for exactly PLL_RST_CYCLES cycles per entry.
- State WAIT_LOCK (encoding 1): pll_rst=0.
  - If lock_s=1, go to STABLE with the counter=1.
  - Else, when the counter reaches LOCK_TIMEOUT-1, increment timeout_count (saturating) and go to PLL_RST.
- State STABLE (encoding 2):
  - If lock_s=0, go to WAIT_LOCK with the counter=0. This is a glitch, not a loss, and is not counted.
  - If lock_s=1 and the counter equals STABLE_CYCLES, go to RUN. Otherwise increment the counter.
- State RUN (encoding 3): stream_reset_n=1, lock_ok=1.
  - If lock_s=0, increment loss_count (saturating) and go to PLL_RST. stream_reset_n drops on that same edge.
- force_relock: from any state except PLL_RST, go to PLL_RST. In PLL_RST it is ignored; the counter is not restarted.
- Priority in RUN: lock_s=0 and force_relock in the same cycle gives one transition to PLL_RST, and loss_count still increments.
- clear_loss: clears both counters. If an increment occurs in the same cycle, the result is 1 (the clear is applied first), so no event is lost.
- Saturation: counters stop at 2^LOSS_W-1 and never wrap.
- Release latency: if pll_locked rises and stays high, with its first high sample at edge k while in WAIT_LOCK, stream_reset_n rises at edge k+SYNC_STAGES+STABLE_CYCLES.
- Reset mid-operation: asserting reset_n returns all outputs to their reset values immediately (asynchronously), including pll_rst=1.
- Counter width: the shared counter is sized clog2 of the max of PLL_RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES+1.

Decomposition:
- Package soc_system_pll_pkg holds:
  - the state enum (PLL_RST, WAIT_LOCK, STABLE, RUN = 0..3);
  - a clog2-based counter-width function;
  - the default parameter constants.
- One sub-module, soc_system_sync_bit: a parameterized N-stage synchronizer with async active-low reset and reset value 0. It is reusable elsewhere.

Test Plan:
All scenarios use SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, LOSS_W=4.
- Power-up clean lock: release reset_n, raise pll_locked 10 cycles later and hold it.
  - pll_rst is high for 4 cycles after reset release.
  - stream_reset_n rises exactly 10 edges after the first high sample of pll_locked (2+8).
  - lock_ok=1, loss_count=0.
- No lock: hold pll_locked=0.
  - pll_rst repeats a 4-cycle pulse every 36 cycles.
  - timeout_count increments per pulse and saturates at 15 after 15 timeouts.
  - stream_reset_n stays 0.
- Glitch during STABLE: drop pll_locked for 1 cycle at count 5.
  - Returns to WAIT_LOCK, stream_reset_n stays 0, loss_count=0.
  - Release occurs 10 edges after locked returns.
- Loss in RUN: drop pll_locked while in RUN.
  - stream_reset_n falls exactly 2 edges after the first low sample.
  - loss_count goes 0→1 and pll_rst pulses for 4 cycles.
  - The full relock sequence completes.
- Simultaneous events in RUN: assert force_relock and clear_loss in the same cycle as lock_s falls, with loss_count=3 beforehand.
  - loss_count=1 and one PLL_RST entry.
  - A force_relock during PLL_RST does not extend the pulse beyond 4 cycles.
- Async reset mid-STABLE: assert reset_n at count 4.
  - pll_rst goes to 1 and stream_reset_n to 0 before the next clk edge.
  - Counters are 0.

Source files
------------

// File: rtl/soc_system_pll_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_pll_pkg
//  Description : Shared types, default constants and helpers for the stream
//                PLL lock monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_system_pll_pkg;

    // Monitor states; the encoding is visible to software through state_o
    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_t;

    localparam int c_DEF_SYNC_STAGES    = 2;
    localparam int c_DEF_PLL_RST_CYCLES = 16;
    localparam int c_DEF_LOCK_TIMEOUT   = 65536;
    localparam int c_DEF_STABLE_CYCLES  = 1024;
    localparam int c_DEF_LOSS_W         = 8;

    // Width of the shared phase counter. STABLE counts up to STABLE_CYCLES
    // inclusive, hence the +1; never narrower than one bit.
    function automatic int cnt_width(input int rst_cycles,
                                     input int lock_timeout,
                                     input int stable_cycles);
        int m;
        m = rst_cycles;
        if (lock_timeout > m)      m = lock_timeout;
        if (stable_cycles + 1 > m) m = stable_cycles + 1;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/soc_system_sync_bit.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_sync_bit
//  Description : N-stage single-bit synchronizer, async active-low reset,
//                resets to 0. Intended for level signals only.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/soc_system_pll_lock_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : soc_system_pll_lock_monitor
//  Description : Sequences the stream PLL reset, qualifies its locked output
//                and releases the stream-domain reset once lock is stable.
//                Re-sequences on timeout, lock loss or software request.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_system_pll_lock_monitor
    import soc_system_pll_pkg::*;
#(
    parameter int SYNC_STAGES    = c_DEF_SYNC_STAGES,
    parameter int PLL_RST_CYCLES = c_DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = c_DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = c_DEF_STABLE_CYCLES,
    parameter int LOSS_W         = c_DEF_LOSS_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_locked,
    input  logic              force_relock,
    input  logic              clear_loss,
    output logic              pll_rst,
    output logic              stream_reset_n,
    output logic              lock_ok,
    output logic [LOSS_W-1:0] loss_count,
    output logic [LOSS_W-1:0] timeout_count,
    output logic [1:0]        state_o
);

    localparam int c_CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_RST_LAST     = c_CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_DONE  = c_CNT_W'(STABLE_CYCLES);
    localparam logic [LOSS_W-1:0]  c_EVT_ONE      = LOSS_W'(1);
    localparam logic [LOSS_W-1:0]  c_EVT_SAT      = '1;

    logic               w_lock_s;
    logic               w_loss_evt;
    logic               w_timeout_evt;

    pll_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_pll_rst;
    logic               r_stream_reset_n;
    logic               r_lock_ok;
    logic [LOSS_W-1:0]  r_loss_count;
    logic [LOSS_W-1:0]  r_timeout_count;

    soc_system_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk    (clk),
        .rst_n  (reset_n),
        .d      (pll_locked),
        .q      (w_lock_s)
    );

    // Events feeding the statistics counters. A loss in RUN still counts when
    // force_relock arrives in the same cycle.
    assign w_loss_evt    = (r_state == RUN) && !w_lock_s;
    assign w_timeout_evt = (r_state == WAIT_LOCK) && !w_lock_s && (r_cnt == c_TIMEOUT_LAST);

    // Sequencer: state, shared phase counter and registered control outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= PLL_RST;
            r_cnt            <= '0;
            r_pll_rst        <= 1'b1;
            r_stream_reset_n <= 1'b0;
            r_lock_ok        <= 1'b0;
        end else if (force_relock && (r_state != PLL_RST)) begin
            // Software request wins; inside PLL_RST it is ignored so the
            // pulse length stays exact.
            r_state          <= PLL_RST;
            r_cnt            <= '0;
            r_pll_rst        <= 1'b1;
            r_stream_reset_n <= 1'b0;
            r_lock_ok        <= 1'b0;
        end else begin
            case (r_state)
                PLL_RST: begin
                    if (r_cnt == c_RST_LAST) begin
                        r_state   <= WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                WAIT_LOCK: begin
                    if (w_lock_s) begin
                        // The lock sample seen here is the first stable cycle
                        r_state <= STABLE;
                        r_cnt   <= c_CNT_ONE;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_state   <= PLL_RST;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                STABLE: begin
                    if (!w_lock_s) begin
                        // Glitch before release: requalify, not a loss
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_STABLE_DONE) begin
                        r_state          <= RUN;
                        r_cnt            <= '0;
                        r_stream_reset_n <= 1'b1;
                        r_lock_ok        <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                RUN: begin
                    if (!w_lock_s) begin
                        r_state          <= PLL_RST;
                        r_cnt            <= '0;
                        r_pll_rst        <= 1'b1;
                        r_stream_reset_n <= 1'b0;
                        r_lock_ok        <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= PLL_RST;
                    r_cnt            <= '0;
                    r_pll_rst        <= 1'b1;
                    r_stream_reset_n <= 1'b0;
                    r_lock_ok        <= 1'b0;
                end
            endcase
        end
    end

    // Saturating event counters; a clear coinciding with an event leaves 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_loss_count    <= '0;
            r_timeout_count <= '0;
        end else if (clear_loss) begin
            r_loss_count    <= w_loss_evt    ? c_EVT_ONE : '0;
            r_timeout_count <= w_timeout_evt ? c_EVT_ONE : '0;
        end else begin
            if (w_loss_evt && (r_loss_count != c_EVT_SAT)) begin
                r_loss_count <= r_loss_count + c_EVT_ONE;
            end
            if (w_timeout_evt && (r_timeout_count != c_EVT_SAT)) begin
                r_timeout_count <= r_timeout_count + c_EVT_ONE;
            end
        end
    end

    assign pll_rst        = r_pll_rst;
    assign stream_reset_n = r_stream_reset_n;
    assign lock_ok        = r_lock_ok;
    assign loss_count     = r_loss_count;
    assign timeout_count  = r_timeout_count;
    assign state_o        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_pll_lock_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_system_pll_lock_monitor
//  Description : Self-checking bench for the stream PLL lock monitor. Expected
//                edges and counts are derived arithmetically from the lock
//                sequencing rules (latencies, pulse periods, saturation).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_system_pll_lock_monitor;

    localparam int SYNC = 2;
    localparam int RSTC = 4;
    localparam int TO   = 32;
    localparam int STB  = 8;
    localparam int LW   = 4;
    localparam int LAT  = SYNC + STB;
    localparam int SAT  = (1 << LW) - 1;

    logic          clk          = 1'b0;
    logic          reset_n      = 1'b0;
    logic          pll_locked   = 1'b0;
    logic          force_relock = 1'b0;
    logic          clear_loss   = 1'b0;
    logic          pll_rst;
    logic          stream_reset_n;
    logic          lock_ok;
    logic [LW-1:0] loss_count;
    logic [LW-1:0] timeout_count;
    logic [1:0]    state_o;

    int edge_cnt = 0;
    int tests    = 0;
    int fails    = 0;
    int rel      = 0;
    int exp_loss = 0;
    int exp_to   = 0;

    soc_system_pll_lock_monitor #(
        .SYNC_STAGES    (SYNC),
        .PLL_RST_CYCLES (RSTC),
        .LOCK_TIMEOUT   (TO),
        .STABLE_CYCLES  (STB),
        .LOSS_W         (LW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .force_relock   (force_relock),
        .clear_loss     (clear_loss),
        .pll_rst        (pll_rst),
        .stream_reset_n (stream_reset_n),
        .lock_ok        (lock_ok),
        .loss_count     (loss_count),
        .timeout_count  (timeout_count),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; pll_locked = 1'b0; force_relock = 1'b0; clear_loss = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        rel = edge_cnt; exp_loss = 0; exp_to = 0;
    endtask

    task automatic lock_up(output int k);
        pll_locked = 1'b1;
        k = edge_cnt + 1;
    endtask

    task automatic wait_srn(input logic val, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            tick();
            if (stream_reset_n === val) at = edge_cnt;
        end
    endtask

    task automatic wait_prst(input logic val, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            if (pll_rst === val) at = edge_cnt;
            else tick();
        end
    endtask

    task automatic reach_run(output bit ok);
        int k, at;
        while (edge_cnt < rel + 10) tick();
        lock_up(k);
        wait_srn(1'b1, LAT + 20, at);
        ok = (at == k + LAT);
    endtask

    task automatic cycle_loss(output bit ok);
        int at;
        ok = 1'b1;
        pll_locked = 1'b0;
        wait_prst(1'b1, 10, at); if (at < 0) ok = 1'b0;
        exp_loss = sat_inc(exp_loss);
        wait_prst(1'b0, 10, at); if (at < 0) ok = 1'b0;
        tick(); tick();
        pll_locked = 1'b1;
        wait_srn(1'b1, LAT + 20, at); if (at < 0) ok = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0; pll_locked = 1'b0; force_relock = 1'b0; clear_loss = 1'b0;
        repeat (3) tick();
        tests++;
        if (pll_rst !== 1'b1 || stream_reset_n !== 1'b0 || lock_ok !== 1'b0 ||
            loss_count !== '0 || timeout_count !== '0 || state_o !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: pll_rst=%b srn=%b lock_ok=%b loss=%0d to=%0d state=%0d, want 1 0 0 0 0 0",
                     pll_rst, stream_reset_n, lock_ok, loss_count, timeout_count, state_o);
        end
        reset_n = 1'b1; rel = edge_cnt; exp_loss = 0; exp_to = 0;
        n = 0;
        while (pll_rst === 1'b1 && n < 20) begin tick(); n++; end
        tests++;
        if (n != RSTC || state_o !== 2'd1) begin
            fails++;
            $display("FAIL reset_pulse: pll_rst high %0d cycles state=%0d, want %0d cycles state=1", n, state_o, RSTC);
        end
    endtask

    task automatic test_clean_lock();
        int d, k, at;
        for (int it = 0; it < 3; it++) begin
            apply_reset();
            d = (it == 0) ? 10 : int'($urandom_range(5, 30));
            while (edge_cnt < rel + d) tick();
            lock_up(k);
            wait_srn(1'b1, LAT + 20, at);
            tests++;
            if (at != k + LAT) begin
                fails++;
                $display("FAIL clean_release: edge %0d, want %0d (delay %0d)", at, k + LAT, d);
            end
            tests++;
            if (lock_ok !== 1'b1 || loss_count !== '0 || state_o !== 2'd3 || pll_rst !== 1'b0) begin
                fails++;
                $display("FAIL clean_run_outputs: lock_ok=%b loss=%0d state=%0d pll_rst=%b, want 1 0 3 0",
                         lock_ok, loss_count, state_o, pll_rst);
            end
        end
    endtask

    task automatic test_no_lock();
        logic prev;
        int   last_rise, last_fall, rises;
        bit   bad_srn;
        apply_reset();
        prev = pll_rst; last_rise = rel; last_fall = rel; rises = 0; bad_srn = 1'b0;
        for (int i = 0; i < 16 * (RSTC + TO) + 10; i++) begin
            tick();
            if (stream_reset_n !== 1'b0) bad_srn = 1'b1;
            if (pll_rst === 1'b1 && prev === 1'b0) begin
                rises++;
                exp_to = sat_inc(exp_to);
                tests++;
                if (edge_cnt - last_rise != RSTC + TO || timeout_count !== LW'(exp_to)) begin
                    fails++;
                    $display("FAIL nolock_period: period %0d to=%0d, want %0d to=%0d",
                             edge_cnt - last_rise, timeout_count, RSTC + TO, exp_to);
                end
                last_rise = edge_cnt;
            end
            if (pll_rst === 1'b0 && prev === 1'b1) begin
                tests++;
                if (edge_cnt - last_rise != RSTC) begin
                    fails++;
                    $display("FAIL nolock_width: width %0d, want %0d", edge_cnt - last_rise, RSTC);
                end
                last_fall = edge_cnt;
            end
            prev = pll_rst;
        end
        tests++;
        if (rises != 16 || bad_srn || timeout_count !== LW'(SAT)) begin
            fails++;
            $display("FAIL nolock_summary: rises=%0d srn_high=%0d to=%0d, want 16 0 %0d", rises, bad_srn, timeout_count, SAT);
        end
        // plain clear inside WAIT_LOCK
        while (edge_cnt < last_fall + 3) tick();
        clear_loss = 1'b1; tick(); clear_loss = 1'b0;
        tests++;
        if (timeout_count !== '0) begin
            fails++;
            $display("FAIL clear_plain: to=%0d, want 0", timeout_count);
        end
        // clear coinciding with a timeout leaves exactly one
        while (edge_cnt < last_fall + TO - 1) tick();
        clear_loss = 1'b1; tick(); clear_loss = 1'b0;
        tests++;
        if (timeout_count !== LW'(1) || pll_rst !== 1'b1) begin
            fails++;
            $display("FAIL clear_with_timeout: to=%0d pll_rst=%b, want 1 1", timeout_count, pll_rst);
        end
    endtask

    task automatic test_glitch();
        int d, k, p, g, at;
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            d = int'($urandom_range(6, 20));
            p = (it == 0) ? 3 : int'($urandom_range(0, 7));
            while (edge_cnt < rel + d) tick();
            lock_up(k);
            while (edge_cnt < k + p) tick();
            pll_locked = 1'b0;
            tick();
            g = edge_cnt;
            pll_locked = 1'b1;
            while (edge_cnt < g + SYNC) tick();
            tests++;
            if (state_o !== 2'd1 || stream_reset_n !== 1'b0) begin
                fails++;
                $display("FAIL glitch_requalify: state=%0d srn=%b, want 1 0 (p=%0d)", state_o, stream_reset_n, p);
            end
            wait_srn(1'b1, LAT + 20, at);
            tests++;
            if (at != g + 1 + LAT || loss_count !== '0) begin
                fails++;
                $display("FAIL glitch_release: edge %0d loss=%0d, want %0d 0", at, loss_count, g + 1 + LAT);
            end
        end
    endtask

    task automatic test_loss_in_run();
        int k, k2, at;
        bit ok;
        apply_reset();
        reach_run(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL loss_setup_run: reached=%0d, want 1", ok); end
        for (int it = 0; it < 17; it++) begin
            repeat ($urandom_range(1, 8)) tick();
            pll_locked = 1'b0;
            k = edge_cnt + 1;
            tick(); tick();
            tests++;
            if (stream_reset_n !== 1'b1) begin
                fails++;
                $display("FAIL loss_early_drop: srn=%b at edge %0d, want 1", stream_reset_n, edge_cnt);
            end
            tick();
            exp_loss = sat_inc(exp_loss);
            tests++;
            if (stream_reset_n !== 1'b0 || pll_rst !== 1'b1 || loss_count !== LW'(exp_loss)) begin
                fails++;
                $display("FAIL loss_drop: srn=%b pll_rst=%b loss=%0d, want 0 1 %0d",
                         stream_reset_n, pll_rst, loss_count, exp_loss);
            end
            while (pll_rst === 1'b1 && edge_cnt < k + 20) tick();
            tests++;
            if (edge_cnt - (k + SYNC) != RSTC) begin
                fails++;
                $display("FAIL loss_pulse: width %0d, want %0d", edge_cnt - (k + SYNC), RSTC);
            end
            repeat ($urandom_range(0, 20)) tick();
            lock_up(k2);
            wait_srn(1'b1, LAT + 20, at);
            tests++;
            if (at != k2 + LAT) begin
                fails++;
                $display("FAIL loss_relock: edge %0d, want %0d", at, k2 + LAT);
            end
        end
    endtask

    task automatic test_force_relock();
        int f, at;
        bit ok;
        apply_reset();
        reach_run(ok);
        force_relock = 1'b1; tick(); force_relock = 1'b0;
        f = edge_cnt;
        tests++;
        if (!ok || pll_rst !== 1'b1 || stream_reset_n !== 1'b0 || state_o !== 2'd0 || loss_count !== '0) begin
            fails++;
            $display("FAIL force_run: run=%0d pll_rst=%b srn=%b state=%0d loss=%0d, want 1 1 0 0 0",
                     ok, pll_rst, stream_reset_n, state_o, loss_count);
        end
        // lock held: PLL_RST, one WAIT_LOCK cycle, then the stable window
        wait_srn(1'b1, 40, at);
        tests++;
        if (at != f + RSTC + 1 + STB) begin
            fails++;
            $display("FAIL force_relock_release: edge %0d, want %0d", at, f + RSTC + 1 + STB);
        end
    endtask

    task automatic test_back_to_back();
        int k, j;
        bit ok, ok1, ok2, ok3;
        apply_reset();
        reach_run(ok);
        cycle_loss(ok1); cycle_loss(ok2); cycle_loss(ok3);
        tests++;
        if (!(ok && ok1 && ok2 && ok3) || loss_count !== LW'(3)) begin
            fails++;
            $display("FAIL b2b_setup: seq_ok=%0d loss=%0d, want 1 3", ok && ok1 && ok2 && ok3, loss_count);
        end
        pll_locked = 1'b0;
        k = edge_cnt + 1;
        tick(); tick();
        force_relock = 1'b1; clear_loss = 1'b1;
        tick();
        force_relock = 1'b0; clear_loss = 1'b0;
        tests++;
        if (loss_count !== LW'(1) || state_o !== 2'd0 || pll_rst !== 1'b1 || stream_reset_n !== 1'b0) begin
            fails++;
            $display("FAIL b2b_simultaneous: loss=%0d state=%0d pll_rst=%b srn=%b, want 1 0 1 0",
                     loss_count, state_o, pll_rst, stream_reset_n);
        end
        j = int'($urandom_range(0, 2));
        repeat (j) tick();
        force_relock = 1'b1; tick(); force_relock = 1'b0;
        while (pll_rst === 1'b1 && edge_cnt < k + 20) tick();
        tests++;
        if (edge_cnt != k + SYNC + RSTC) begin
            fails++;
            $display("FAIL b2b_force_in_rst: pulse ends edge %0d, want %0d (j=%0d)", edge_cnt, k + SYNC + RSTC, j);
        end
    endtask

    task automatic test_async_reset();
        int k, at;
        bit ok, ok1;
        apply_reset();
        reach_run(ok);
        cycle_loss(ok1);
        pll_locked = 1'b0;
        wait_prst(1'b1, 10, at);
        exp_loss = sat_inc(exp_loss);
        wait_prst(1'b0, 10, at);
        tick();
        lock_up(k);
        while (edge_cnt < k + SYNC + 3) tick();
        tests++;
        if (!(ok && ok1) || at < 0 || state_o !== 2'd2 || loss_count !== LW'(exp_loss)) begin
            fails++;
            $display("FAIL async_setup: seq_ok=%0d state=%0d loss=%0d, want 1 2 %0d",
                     ok && ok1 && at >= 0, state_o, loss_count, exp_loss);
        end
        #3 reset_n = 1'b0;
        #1;
        tests++;
        if (pll_rst !== 1'b1 || stream_reset_n !== 1'b0 || lock_ok !== 1'b0 ||
            loss_count !== '0 || timeout_count !== '0 || state_o !== 2'd0) begin
            fails++;
            $display("FAIL async_reset: pll_rst=%b srn=%b lock_ok=%b loss=%0d to=%0d state=%0d, want 1 0 0 0 0 0",
                     pll_rst, stream_reset_n, lock_ok, loss_count, timeout_count, state_o);
        end
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_lock();
        test_no_lock();
        test_glitch();
        test_loss_in_run();
        test_force_relock();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
